// File: rtl/arm_defs.sv
// Shared ARM core definitions: ALU opcodes, CPSR flag positions and the
// multiply sequencer state encoding.
package arm_defs;

   localparam int XLEN = 32;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_EOR = 4'b0001;
   localparam logic [3:0] ALU_SUB = 4'b0010;
   localparam logic [3:0] ALU_RSB = 4'b0011;
   localparam logic [3:0] ALU_ADD = 4'b0100;
   localparam logic [3:0] ALU_ADC = 4'b0101;
   localparam logic [3:0] ALU_SBC = 4'b0110;
   localparam logic [3:0] ALU_RSC = 4'b0111;
   localparam logic [3:0] ALU_TST = 4'b1000;
   localparam logic [3:0] ALU_TEQ = 4'b1001;
   localparam logic [3:0] ALU_CMP = 4'b1010;
   localparam logic [3:0] ALU_CMN = 4'b1011;
   localparam logic [3:0] ALU_ORR = 4'b1100;
   localparam logic [3:0] ALU_MOV = 4'b1101;
   localparam logic [3:0] ALU_BIC = 4'b1110;
   localparam logic [3:0] ALU_MVN = 4'b1111;

   localparam int CPSR_N = 31;
   localparam int CPSR_Z = 30;
   localparam int CPSR_C = 29;
   localparam int CPSR_V = 28;

   typedef enum logic [1:0] {
      MUL_IDLE  = 2'd0,
      MUL_ITER  = 2'd1,
      MUL_FLAGS = 2'd2,
      MUL_DONE  = 2'd3
   } mul_state_e;

   function automatic logic [XLEN-1:0] partial_term(
      input logic            sel,
      input logic [XLEN-1:0] mcand
   );
      return sel ? mcand : '0;
   endfunction

endpackage

// File: rtl/arm_mul_seq.sv
// Radix-2 shift-add MUL/MLA sequencer borrowing the shared ALU.
// Optional ARM_MUL_EARLY_TERM_EN: finish once the multiplier is exhausted.
module arm_mul_seq
   import arm_defs::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            accumulate,
   input  logic            s_bit,
   input  logic [XLEN-1:0] rm,
   input  logic [XLEN-1:0] rs,
   input  logic [XLEN-1:0] rn,
   input  logic [XLEN-1:0] cpsr_in,
   output logic [XLEN-1:0] alu_op1,
   output logic [XLEN-1:0] alu_op2,
   output logic [3:0]      alu_op_sel,
   output logic [XLEN-1:0] alu_cpsr_prev,
   input  logic [XLEN-1:0] alu_out,
   input  logic [XLEN-1:0] alu_cpsr_next,
   output logic            alu_own,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [XLEN-1:0] cpsr_out,
   output logic            cpsr_we
);

   mul_state_e      state;
   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] mplier;
   logic [4:0]      cnt;
   logic [XLEN-1:0] cpsr_q;
   logic            s_q;
   logic            skip;

`ifdef ARM_MUL_EARLY_TERM_EN
   assign skip = (mplier == '0);
`else
   assign skip = 1'b0;
`endif

   assign busy = alu_own;

   always_comb begin
      alu_op1       = '0;
      alu_op2       = '0;
      alu_op_sel    = ALU_MOV;
      alu_cpsr_prev = cpsr_in;
      case (state)
         MUL_ITER: begin
            alu_op1       = acc;
            alu_op2       = partial_term(mplier[0], mcand);
            alu_op_sel    = ALU_ADD;
            alu_cpsr_prev = cpsr_q;
         end
         MUL_FLAGS: begin
            alu_op2       = acc;
            alu_op_sel    = ALU_MOV;
            alu_cpsr_prev = cpsr_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= MUL_IDLE;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
         cpsr_q   <= '0;
         s_q      <= 1'b0;
         result   <= '0;
         cpsr_out <= '0;
         done     <= 1'b0;
         cpsr_we  <= 1'b0;
         alu_own  <= 1'b0;
      end else begin
         case (state)
            MUL_IDLE: begin
               if (start) begin
                  acc     <= accumulate ? rn : '0;
                  mcand   <= rm;
                  mplier  <= rs;
                  cnt     <= '0;
                  cpsr_q  <= cpsr_in;
                  s_q     <= s_bit;
                  alu_own <= 1'b1;
                  state   <= MUL_ITER;
               end
            end
            MUL_ITER: begin
               // ITER C/V are discarded; only the running sum matters.
               if (!skip) begin
                  acc    <= alu_out;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + 5'd1;
               end
               if (skip || cnt == 5'd31) begin
                  state <= MUL_FLAGS;
               end
            end
            MUL_FLAGS: begin
               result   <= alu_out;
               cpsr_out <= alu_cpsr_next;
               done     <= 1'b1;
               cpsr_we  <= s_q;
               state    <= MUL_DONE;
            end
            MUL_DONE: begin
               done    <= 1'b0;
               cpsr_we <= 1'b0;
               alu_own <= 1'b0;
               state   <= MUL_IDLE;
            end
            default: state <= MUL_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arm_mul_seq.sv
// Self-checking bench for arm_mul_seq with a behavioural ALU and
// arithmetic reference model; honours ARM_MUL_EARLY_TERM_EN if defined.
module tb_arm_mul_seq;
   import arm_defs::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        accumulate;
   logic        s_bit;
   logic [31:0] rm, rs, rn, cpsr_in;
   logic [31:0] alu_op1, alu_op2, alu_cpsr_prev;
   logic [3:0]  alu_op_sel;
   logic [31:0] alu_out, alu_cpsr_next;
   logic        alu_own, busy, done, cpsr_we;
   logic [31:0] result, cpsr_out;

   int errors = 0;
   int checks = 0;
   logic [31:0] last_res = '0;
   logic [31:0] last_cpsr = '0;

   always #5 clk = ~clk;

   arm_mul_seq dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .accumulate    (accumulate),
      .s_bit         (s_bit),
      .rm            (rm),
      .rs            (rs),
      .rn            (rn),
      .cpsr_in       (cpsr_in),
      .alu_op1       (alu_op1),
      .alu_op2       (alu_op2),
      .alu_op_sel    (alu_op_sel),
      .alu_cpsr_prev (alu_cpsr_prev),
      .alu_out       (alu_out),
      .alu_cpsr_next (alu_cpsr_next),
      .alu_own       (alu_own),
      .busy          (busy),
      .done          (done),
      .result        (result),
      .cpsr_out      (cpsr_out),
      .cpsr_we       (cpsr_we)
   );

   // Behavioural shared ALU: ADD sets all four flags, MOV sets N/Z only.
   always_comb begin
      logic [32:0] sum;
      sum           = {1'b0, alu_op1} + {1'b0, alu_op2};
      alu_out       = '0;
      alu_cpsr_next = alu_cpsr_prev;
      if (alu_op_sel == ALU_ADD) begin
         alu_out       = sum[31:0];
         alu_cpsr_next = {sum[31], sum[31:0] == 0, sum[32],
                          (alu_op1[31] == alu_op2[31]) && (sum[31] != alu_op1[31]),
                          alu_cpsr_prev[27:0]};
      end else if (alu_op_sel == ALU_MOV) begin
         alu_out       = alu_op2;
         alu_cpsr_next = {alu_op2[31], alu_op2 == 0, alu_cpsr_prev[29:0]};
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_lat(input logic [31:0] rs_v);
`ifdef ARM_MUL_EARLY_TERM_EN
      int hi = -1;
      int l;
      for (int i = 0; i < 32; i++) if (rs_v[i]) hi = i;
      l = 3 + hi + 1;
      return (l > 34) ? 34 : l;
`else
      return 34;
`endif
   endfunction

   task automatic run_op(input logic acc_v, input logic s_v,
                         input logic [31:0] rm_v, input logic [31:0] rs_v,
                         input logic [31:0] rn_v, input logic [31:0] cp_v,
                         input int glitch_c, input int rst_c);
      logic [31:0] er, ec;
      logic [3:0]  eo;
      int lat, done_at, ndone;
      er = rm_v * rs_v + (acc_v ? rn_v : 32'd0);
      ec = {er[31], er == 0, cp_v[29:0]};
      lat = exp_lat(rs_v);
      done_at = -1;
      ndone = 0;
      @(negedge clk);
      accumulate = acc_v; s_bit = s_v;
      rm = rm_v; rs = rs_v; rn = rn_v; cpsr_in = cp_v;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      rm = $urandom; rs = $urandom; rn = $urandom; cpsr_in = $urandom;
      accumulate = ~acc_v; s_bit = ~s_v;
      for (int c = 1; c <= 40; c++) begin
         if (c == glitch_c) begin
            start = 1'b1;
            rm = $urandom; rs = $urandom; rn = $urandom;
         end
         if (c == glitch_c + 1) start = 1'b0;
         if (rst_c > 0 && c == rst_c) rst_n = 1'b0;
         if (rst_c > 0 && c == rst_c + 1) begin
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_own", {31'd0, alu_own}, 32'd0);
            rst_n = 1'b1;
         end
         if (done) begin
            ndone++;
            if (done_at < 0) done_at = c;
         end
         if (rst_c < 0 || c <= rst_c) begin
            if (c < lat) begin
               eo = (c < lat - 1) ? ALU_ADD : ALU_MOV;
               chk("own", {31'd0, alu_own}, 32'd1);
               chk("busy", {31'd0, busy}, 32'd1);
               chk("op_sel", {28'd0, alu_op_sel}, {28'd0, eo});
               chk("hold_res", result, last_res);
               chk("early_we", {31'd0, cpsr_we}, 32'd0);
               if (c == lat - 1) chk("flags_op2", alu_op2, er);
            end else if (c == lat) begin
               chk("done_res", result, er);
               chk("done_cpsr", cpsr_out, ec);
               chk("done_we", {31'd0, cpsr_we}, {31'd0, s_v});
               chk("done_own", {31'd0, alu_own}, 32'd1);
            end else if (c == lat + 1) begin
               chk("idle_busy", {31'd0, busy}, 32'd0);
               chk("idle_done", {31'd0, done}, 32'd0);
               chk("idle_res", result, er);
            end
         end
         @(posedge clk); #1;
      end
      if (rst_c < 0) begin
         chk("done_cycle", done_at, lat);
         chk("done_count", ndone, 32'd1);
         last_res = er;
         last_cpsr = ec;
      end else begin
         chk("rst_ndone", ndone, 32'd0);
         chk("rst_res", result, 32'd0);
         chk("rst_cpsr", cpsr_out, 32'd0);
         last_res = '0;
         last_cpsr = '0;
      end
   endtask

   initial begin
      logic [31:0] r_rs;
      rst_n = 1'b0; start = 1'b0; accumulate = 1'b0; s_bit = 1'b0;
      rm = '0; rs = '0; rn = '0; cpsr_in = 32'h1234_5678;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", result, 32'd0);
      chk("rst_cpsr_out", cpsr_out, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_we", {31'd0, cpsr_we}, 32'd0);
      chk("rst_busy0", {31'd0, busy}, 32'd0);
      chk("idle_sel", {28'd0, alu_op_sel}, {28'd0, ALU_MOV});
      chk("idle_prev", alu_cpsr_prev, 32'h1234_5678);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(1'b0, 1'b1, 32'd5, 32'd3, 32'd0, 32'h2000_0000, -1, -1);
      run_op(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'h0, -1, -1);
      run_op(1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'd9,
             32'h1000_0000, -1, -1);
      run_op(1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'd9,
             32'h1000_0000, -1, -1);
      run_op(1'b1, 1'b1, 32'd11, 32'd13, 32'd17, 32'hF000_0000, 5, -1);
      run_op(1'b1, 1'b1, 32'd11, 32'd13, 32'd17, 32'hF000_0000, -1, 10);
      run_op(1'b1, 1'b1, 32'd123, 32'd0, 32'hDEAD_BEEF, 32'h3000_0000, -1, -1);
      run_op(1'b0, 1'b0, 32'd123, 32'd0, 32'hDEAD_BEEF, 32'h3000_0000, -1, -1);
      run_op(1'b0, 1'b1, 32'd7, 32'd1, 32'd0, 32'h0, -1, -1);
      run_op(1'b0, 1'b1, 32'h8000_0001, 32'h8000_0000, 32'd0, 32'h0, -1, -1);

      for (int i = 0; i < 20; i++) begin
         r_rs = 32'($urandom) >> $urandom_range(0, 32);
         run_op(1'($urandom), 1'($urandom), $urandom, r_rs, $urandom,
                $urandom, -1, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
